sysarr_out_drain_ctrl: RTL and testbench



---
 rtl/sysarr_pkg.sv | 16 +
 rtl/sysarr_row_addr_gen.sv | 41 ++++
 rtl/sysarr_out_drain_ctrl.sv | 103 ++++++++++
 tb/tb_sysarr_out_drain_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sysarr_pkg.sv
// Shared types and defaults for the systolic-array output drain controller.
package sysarr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN,
        DONE
    } drain_state_t;

    localparam int unsigned SYSARR_N           = 4;
    localparam int unsigned ROW_IDX_W          = $clog2(SYSARR_N);
    localparam int unsigned DEFAULT_ADDR_W     = 16;
    localparam int unsigned DEFAULT_ROW_STRIDE = 4;

endpackage

// File: rtl/sysarr_row_addr_gen.sv
// Drain-phase row addressing: latches the tile base, counts rows and forms
// wr_addr = base + row * ROW_STRIDE (modulo 2^ADDR_W) plus the row-mux select.
module sysarr_row_addr_gen
    import sysarr_pkg::*;
#(
    parameter int unsigned N          = SYSARR_N,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned ROW_STRIDE = DEFAULT_ROW_STRIDE,
    parameter int unsigned SEL_W      = ROW_IDX_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              advance,
    output logic              last,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SEL_W-1:0]  wr_row_sel
);

    logic [ADDR_W-1:0] base_q;
    logic [SEL_W-1:0]  drain_cnt_q;

    assign last       = (drain_cnt_q == SEL_W'(N - 1));
    assign wr_row_sel = drain_cnt_q;
    assign wr_addr    = base_q + ADDR_W'(ROW_STRIDE) * ADDR_W'(drain_cnt_q);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            base_q      <= '0;
            drain_cnt_q <= '0;
        end else if (load) begin
            base_q      <= load_base;
            drain_cnt_q <= '0;
        end else if (advance) begin
            // Explicit clear keeps the count correct for non-power-of-two N.
            drain_cnt_q <= last ? '0 : drain_cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sysarr_out_drain_ctrl.sv
// Fill/drain sequencer for one N x N result tile of the systolic array output FIFOs.
// Optional stall counter output enabled by defining SYSARR_DRAIN_PERF_EN.
module sysarr_out_drain_ctrl
    import sysarr_pkg::*;
#(
    parameter int unsigned N          = SYSARR_N,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned ROW_STRIDE = DEFAULT_ROW_STRIDE,
    localparam int unsigned SEL_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              res_valid,
    output logic              res_ready,
    output logic              fifo_shift,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [SEL_W-1:0]  wr_row_sel,
    output logic              busy,
    output logic              done
`ifdef SYSARR_DRAIN_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    drain_state_t     state_q, state_d;
    logic [SEL_W-1:0] fill_cnt_q;
    logic             accept_start;
    logic             fill_last;
    logic             drain_last;
    logic             wr_hs;

    assign accept_start = (state_q == IDLE) && start;
    assign fifo_shift   = res_valid && res_ready;
    assign wr_hs        = wr_valid && wr_ready;
    assign fill_last    = (fill_cnt_q == SEL_W'(N - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FILL;
            FILL:    if (fifo_shift && fill_last) state_d = DRAIN;
            DRAIN:   if (wr_hs && drain_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            fill_cnt_q <= '0;
            res_ready  <= 1'b0;
            wr_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fifo_shift) begin
                fill_cnt_q <= fill_last ? '0 : fill_cnt_q + 1'b1;
            end
            res_ready <= (state_d == FILL);
            wr_valid  <= (state_d == DRAIN);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

    sysarr_row_addr_gen #(
        .N          (N),
        .ADDR_W     (ADDR_W),
        .ROW_STRIDE (ROW_STRIDE),
        .SEL_W      (SEL_W)
    ) u_row_addr_gen (
        .clk        (clk),
        .RST        (RST),
        .load       (accept_start),
        .load_base  (base_addr),
        .advance    (wr_hs),
        .last       (drain_last),
        .wr_addr    (wr_addr),
        .wr_row_sel (wr_row_sel)
    );

`ifdef SYSARR_DRAIN_PERF_EN
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_cnt <= '0;
        end else if (accept_start) begin
            stall_cnt <= '0;
        end else if (wr_valid && !wr_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sysarr_out_drain_ctrl.sv
// Scoreboard bench for sysarr_out_drain_ctrl (N=4, ADDR_W=16, ROW_STRIDE=4).
module tb_sysarr_out_drain_ctrl;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = '0;
    logic        res_valid = 1'b0;
    logic        res_ready;
    logic        fifo_shift;
    logic        wr_valid;
    logic        wr_ready = 1'b0;
    logic [15:0] wr_addr;
    logic [1:0]  wr_row_sel;
    logic        busy;
    logic        done;
`ifdef SYSARR_DRAIN_PERF_EN
    logic [15:0] stall_cnt;
`endif

    sysarr_out_drain_ctrl #(
        .N          (4),
        .WIDTH      (16),
        .ADDR_W     (16),
        .ROW_STRIDE (4)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .start      (start),
        .base_addr  (base_addr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .fifo_shift (fifo_shift),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_row_sel (wr_row_sel),
        .busy       (busy),
        .done       (done)
`ifdef SYSARR_DRAIN_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  sel;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every write handshake and checks stall stability.
    logic        stalled_prev = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [1:0]  prev_sel = '0;

    always @(negedge clk) begin
        if (RST) begin
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_hold_valid", 32'(wr_valid), 32'd1);
                check("stall_hold_addr", 32'(wr_addr), 32'(prev_addr));
                check("stall_hold_sel", 32'(wr_row_sel), 32'(prev_sel));
            end
            if (wr_valid && wr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL wr_unexpected: got addr %0h sel %0d expected no write",
                             wr_addr, wr_row_sel);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(exp_e.addr));
                    check("wr_row_sel", 32'(wr_row_sel), 32'(exp_e.sel));
                end
            end
            stalled_prev = wr_valid && !wr_ready;
            prev_addr    = wr_addr;
            prev_sel     = wr_row_sel;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] a3);
        exp_q.push_back('{addr: a0, sel: 2'd0});
        exp_q.push_back('{addr: a1, sel: 2'd1});
        exp_q.push_back('{addr: a2, sel: 2'd2});
        exp_q.push_back('{addr: a3, sel: 2'd3});
    endtask

    // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle 1.
    task automatic issue_start(input logic [15:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else tick();
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        tick();
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pat [7];
        int nshift;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_res_ready", 32'(res_ready), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        RST = 1'b0;
        tick();

        // Cycle-accurate tile at base 0x0100
        push4(16'h0100, 16'h0104, 16'h0108, 16'h010C);
        res_valid = 1'b1;
        wr_ready  = 1'b1;
        issue_start(16'h0100);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check($sformatf("lat_shift_c%0d", k), 32'(fifo_shift), 32'(k <= 4));
            check($sformatf("lat_wr_valid_c%0d", k), 32'(wr_valid), 32'(k >= 5 && k <= 8));
            check($sformatf("lat_done_c%0d", k), 32'(done), 32'(k == 9));
            check($sformatf("lat_busy_c%0d", k), 32'(busy), 32'(k <= 9));
            tick();
        end
        check("lat_queue_empty", 32'(exp_q.size()), 32'd0);

        // Sparse res_valid pattern
        push4(16'h0200, 16'h0204, 16'h0208, 16'h020C);
        res_valid = 1'b0;
        issue_start(16'h0200);
        nshift = 0;
        for (int k = 0; k < 7; k++) begin
            res_valid = pat[k];
            @(negedge clk);
            check($sformatf("pat_shift_%0d", k), 32'(fifo_shift), 32'(pat[k]));
            check($sformatf("pat_no_wr_%0d", k), 32'(wr_valid), 32'd0);
            nshift += int'(fifo_shift);
            tick();
        end
        res_valid = 1'b1;  // outside FILL this must not shift
        @(negedge clk);
        check("pat_drain_entry", 32'(wr_valid), 32'd1);
        check("pat_no_shift_in_drain", 32'(fifo_shift), 32'd0);
        check("pat_shift_count", 32'(nshift), 32'd4);
        tick();
        wait_done("pat");

        // Back-pressure on row 2
        push4(16'h0300, 16'h0304, 16'h0308, 16'h030C);
        issue_start(16'h0300);
        repeat (6) tick();
        wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall_addr_%0d", k), 32'(wr_addr), 32'h0308);
            check($sformatf("stall_sel_%0d", k), 32'(wr_row_sel), 32'd2);
            check($sformatf("stall_valid_%0d", k), 32'(wr_valid), 32'd1);
            tick();
        end
        wr_ready = 1'b1;
        wait_done("stall");
`ifdef SYSARR_DRAIN_PERF_EN
        check("stall_cnt", 32'(stall_cnt), 32'd3);
`endif

        // Address wrap
        push4(16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004);
        issue_start(16'hFFF8);
        wait_done("wrap");

        // start pulsed in FILL, DRAIN and DONE is ignored
        push4(16'h0400, 16'h0404, 16'h0408, 16'h040C);
        issue_start(16'h0400);
        for (int k = 1; k <= 10; k++) begin
            start     = (k == 2 || k == 6 || k == 9);
            base_addr = start ? 16'h0AAA : 16'h0400;
            @(negedge clk);
            if (k == 9) check("ign_done_c9", 32'(done), 32'd1);
            if (k == 10) check("ign_idle_c10", 32'(busy), 32'd0);
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        check("ign_no_restart", 32'(busy), 32'd0);
        check("ign_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Reset mid-DRAIN after two writes
        exp_q.push_back('{addr: 16'h0500, sel: 2'd0});
        exp_q.push_back('{addr: 16'h0504, sel: 2'd1});
        issue_start(16'h0500);
        repeat (6) tick();
        #1;
        RST = 1'b1;
        #1;
        check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_res_ready", 32'(res_ready), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
        check("mid_rst_sel", 32'(wr_row_sel), 32'd0);
        check("mid_rst_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        RST = 1'b0;
        tick();
        push4(16'h0600, 16'h0604, 16'h0608, 16'h060C);
        issue_start(16'h0600);
        wait_done("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
